char_map: RTL and testbench

// - Character-cell text-overlay generator: maps a raster position (hcnt, vcnt) to a tile-index RAM address.
// - Uses the fetched tile code plus the pixel row within the cell to address a font ROM.
// - Outputs a 1-bit overlay mask 'a' per pixel; the parent mixes a fixed colour where a=1.
// - Sits between the video timing counters and two external synchronous-read RAMs (tile map, font).

---
 rtl/char_map_if.sv | 20 ++
 rtl/char_map.sv | 42 ++++
 tb/tb_char_map.sv | 138 +++++++++++++
 3 files changed

// File: rtl/char_map_if.sv
// rtl/char_map_if.sv - raster position in, tile/font RAM addresses and data, overlay mask out
interface char_map_if;
  logic [9:0]  hcnt;
  logic [9:0]  vcnt;
  logic [7:0]  chmap_data_out;
  logic [7:0]  chrom_data_out;
  logic [11:0] chram_addr;
  logic [11:0] chrom_addr;
  logic        a;

  modport master (
    output hcnt, vcnt, chmap_data_out, chrom_data_out,
    input  chram_addr, chrom_addr, a
  );

  modport slave (
    input  hcnt, vcnt, chmap_data_out, chrom_data_out,
    output chram_addr, chrom_addr, a
  );
endinterface

// File: rtl/char_map.sv
// rtl/char_map.sv - 32x32 character-cell overlay: tile fetch, font fetch, 1-bit pixel mask
module char_map #(
  parameter int H_ACTIVE = 256,
  parameter int V_ACTIVE = 256
) (
  input  logic       clk,
  input  logic       reset,
  char_map_if.slave  bus
);
  logic       in_win;
  logic [2:0] hcnt_d1;
  logic [2:0] vcnt_d1;
  logic       win_d1;
  logic [2:0] hcnt_d2;
  logic       win_d2;

  assign in_win = (bus.hcnt < 10'(H_ACTIVE)) && (bus.vcnt < 10'(V_ACTIVE));

  // Tile RAM address tracks the counters directly; the RAM supplies the one-clock delay.
  assign bus.chram_addr = {2'b00, bus.vcnt[7:3], bus.hcnt[7:3]};

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_d1 <= 3'd0;
      vcnt_d1 <= 3'd0;
      win_d1  <= 1'b0;
      hcnt_d2 <= 3'd0;
      win_d2  <= 1'b0;
    end else begin
      hcnt_d1 <= bus.hcnt[2:0];
      vcnt_d1 <= bus.vcnt[2:0];
      win_d1  <= in_win;
      hcnt_d2 <= hcnt_d1;
      win_d2  <= win_d1;
    end
  end

  assign bus.chrom_addr = {1'b0, bus.chmap_data_out, vcnt_d1};

  // Font bit 7 is the leftmost pixel of the cell.
  assign bus.a = win_d2 & bus.chrom_data_out[3'd7 - hcnt_d2];
endmodule

// File: tb/tb_char_map.sv
// tb/tb_char_map.sv - randomized and directed checks of char_map against a cell/font reference model
module tb_char_map;
  logic clk = 1'b0;
  logic reset;
  char_map_if bus ();

  char_map #(.H_ACTIVE(256), .V_ACTIVE(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] tile [1024];
  logic [7:0] font [2048];

  // Synchronous-read tile RAM and font ROM
  always @(posedge clk) begin
    bus.chmap_data_out <= tile[bus.chram_addr[9:0]];
    bus.chrom_data_out <= font[bus.chrom_addr[10:0]];
  end

  int n_tests = 0;
  int n_fail  = 0;
  int prev_h  = 0;
  int prev_v  = 0;
  bit prev_ok = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit in_win(int h, int v);
    return (h < 256) && (v < 256);
  endfunction

  function automatic int cell_addr(int h, int v);
    return (v / 8) * 32 + (h / 8);
  endfunction

  function automatic bit pixel(int h, int v);
    logic [7:0] row_bits;
    if (!in_win(h, v)) return 1'b0;
    row_bits = font[int'(tile[cell_addr(h, v)]) * 8 + (v % 8)];
    return row_bits[7 - (h % 8)];
  endfunction

  // One pixel clock: present a position, clock it, check the mask for the previous position.
  task automatic step(input int h, input int v, input bit r);
    bit exp_a;
    bus.hcnt = 10'(h);
    bus.vcnt = 10'(v);
    reset    = r;
    #1;
    if (in_win(h, v)) check("chram_addr", 32'(bus.chram_addr), 32'(cell_addr(h, v)));
    @(posedge clk);
    #1;
    exp_a = prev_ok && !r && pixel(prev_h, prev_v);
    check("a", 32'(bus.a), 32'(exp_a));
    if (!r && in_win(h, v))
      check("chrom_addr", 32'(bus.chrom_addr), 32'(int'(tile[cell_addr(h, v)]) * 8 + (v % 8)));
    prev_h  = h;
    prev_v  = v;
    prev_ok = !r;
  endtask

  initial begin
    bus.hcnt = '0;
    bus.vcnt = '0;
    reset    = 1'b1;
    for (int i = 0; i < 1024; i++) tile[i] = 8'($urandom);
    for (int i = 0; i < 2048; i++) font[i] = 8'hFF;

    // Reset held 3 clocks, font all ones: mask low through reset and one clock more, then high
    for (int i = 0; i < 3; i++) step(0, 0, 1'b1);
    step(0, 0, 1'b0);
    check("a_after_rel1", 32'(bus.a), 32'd0);
    step(0, 0, 1'b0);
    check("a_after_rel2", 32'(bus.a), 32'd1);

    // Window edges with an all-ones font
    step(255, 10, 1'b0);
    step(256, 10, 1'b0);
    check("a_h255", 32'(bus.a), 32'd1);
    step(10, 256, 1'b0);
    check("a_h256", 32'(bus.a), 32'd0);
    step(10, 255, 1'b0);
    check("a_v256", 32'(bus.a), 32'd0);
    step(0, 0, 1'b0);
    check("a_v255", 32'(bus.a), 32'd1);

    for (int i = 0; i < 2048; i++) font[i] = 8'($urandom);

    // Address examples
    tile[136] = 8'h7F;
    step(64, 32, 1'b0);
    check("chram_136", 32'(bus.chram_addr), 32'd136);
    check("chrom_3f8", 32'(bus.chrom_addr), 32'h3F8);
    tile[331] = 8'h2A;
    step(88, 83, 1'b0);
    check("chram_331", 32'(bus.chram_addr), 32'd331);
    check("chrom_153", 32'(bus.chrom_addr), 32'h153);

    // Single leftmost-pixel font row swept across cell (0,0)
    tile[0] = 8'h05;
    font[40] = 8'h80;
    for (int i = 0; i < 8; i++) begin
      step(i, 0, 1'b0);
      if (i > 0) check("sweep", 32'(bus.a), 32'(i == 1));
    end
    step(8, 0, 1'b0);
    check("sweep_last", 32'(bus.a), 32'd0);

    // Tile rewrite between frames is seen on the next fetch
    tile[136] = 8'hA6;
    step(64, 33, 1'b0);
    check("chrom_a6", 32'(bus.chrom_addr), 32'(8'hA6 * 8 + 1));
    tile[136] = 8'h7F;
    step(64, 33, 1'b0);
    check("chrom_7f", 32'(bus.chrom_addr), 32'(8'h7F * 8 + 1));

    // Random positions, including outside the window and occasional mid-frame resets
    for (int i = 0; i < 600; i++)
      step(int'($urandom_range(0, 299)), int'($urandom_range(0, 299)), ($urandom_range(0, 39) == 0));

    // Raster-ordered run across a few lines
    for (int v = 250; v < 258; v++)
      for (int h = 240; h < 262; h++) step(h, v, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
